// File: rtl/alu_mul_sequencer_if.sv
// Handshake and shared-ALU bundle between the multiply sequencer and the
// datapath that owns the ALU.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             alu_req;
  logic [WIDTH-1:0] alu_src1;
  logic [WIDTH-1:0] alu_src2;
  logic [5:0]       alu_operation;
  logic [4:0]       alu_shamt;
  logic [WIDTH-1:0] alu_result;

  // Sequencer side
  modport slave (
    input  start, mcand, mplier, alu_result,
    output busy, done, product, alu_req, alu_src1, alu_src2, alu_operation, alu_shamt
  );

  // Requester / ALU-owning datapath side
  modport master (
    output start, mcand, mplier, alu_result,
    input  busy, done, product, alu_req, alu_src1, alu_src2, alu_operation, alu_shamt
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32 (low word) multiplier that borrows the shared ALU for
// every add and shift. Define MUL_EARLY_EXIT_EN to stop once no multiplier bits remain.
module alu_mul_sequencer #(
  parameter int         WIDTH  = 32,
  parameter logic [5:0] OP_ADD = 6'd27,
  parameter logic [5:0] OP_SLL = 6'd32
) (
  input logic                 clk,
  input logic                 rst,
  alu_mul_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mc;
  logic [WIDTH-1:0] r_mp;
  logic [4:0]       r_cnt;
  logic [WIDTH-1:0] r_product;
  logic             w_shift_last;
  logic             w_start_zero;

`ifdef MUL_EARLY_EXIT_EN
  assign w_shift_last = (r_cnt == 5'd31) || (r_mp[WIDTH-1:1] == '0);
  assign w_start_zero = (bus.mplier == '0);
`else
  assign w_shift_last = (r_cnt == 5'd31);
  assign w_start_zero = 1'b0;
`endif

  // NOTE: state registers use non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_mc      <= '0;
      r_mp      <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc     <= '0;
            r_mc      <= bus.mcand;
            r_mp      <= bus.mplier;
            r_cnt     <= '0;
            r_product <= '0;
            if (w_start_zero)       r_state <= S_DONE;
            else if (bus.mplier[0]) r_state <= S_ADD;
            else                    r_state <= S_SHIFT;
          end
        end
        S_ADD: begin
          r_acc   <= bus.alu_result;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_mc  <= bus.alu_result;
          r_mp  <= r_mp >> 1;
          r_cnt <= r_cnt + 5'd1;
          // acc is final here, so product is already valid during DONE
          if (w_shift_last) begin
            r_product <= r_acc;
            r_state   <= S_DONE;
          end else begin
            r_state <= r_mp[1] ? S_ADD : S_SHIFT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    bus.alu_req       = 1'b0;
    bus.alu_src1      = '0;
    bus.alu_src2      = '0;
    bus.alu_operation = '0;
    bus.alu_shamt     = '0;
    case (r_state)
      S_ADD: begin
        bus.alu_req       = 1'b1;
        bus.alu_src1      = r_acc;
        bus.alu_src2      = r_mc;
        bus.alu_operation = OP_ADD;
      end
      S_SHIFT: begin
        bus.alu_req       = 1'b1;
        bus.alu_src2      = r_mc;
        bus.alu_operation = OP_SLL;
        bus.alu_shamt     = 5'd1;
      end
      default: ;
    endcase
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign bus.product = r_product;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench: ALU stand-in plus a bit-serial reference that predicts
// the exact ALU request stream, product and done cycle for each multiply.
module tb_alu_mul_sequencer;

  localparam logic [5:0] OP_ADD = 6'd27;
  localparam logic [5:0] OP_SLL = 6'd32;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
  } alu_step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  alu_mul_sequencer_if #(.WIDTH(32)) bus ();

  alu_mul_sequencer #(.WIDTH(32), .OP_ADD(OP_ADD), .OP_SLL(OP_SLL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Combinational shared ALU
  assign bus.alu_result = (bus.alu_operation == OP_ADD) ? bus.alu_src1 + bus.alu_src2 :
                          (bus.alu_operation == OP_SLL) ? bus.alu_src2 << bus.alu_shamt :
                          32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected ALU traffic: per multiplier bit, an optional add then a shift.
  task automatic build_model(input logic [31:0] a, input logic [31:0] b,
                             output alu_step_t q[$]);
    logic [31:0] acc;
    int          nbits;
    acc   = 0;
    nbits = 32;
`ifdef MUL_EARLY_EXIT_EN
    nbits = 0;
    for (int i = 0; i < 32; i++) if (b[i]) nbits = i + 1;
`endif
    q.delete();
    for (int i = 0; i < nbits; i++) begin
      if (b[i]) begin
        q.push_back('{op: OP_ADD, src1: acc, src2: a << i, shamt: 5'd0});
        acc = acc + (a << i);
      end
      q.push_back('{op: OP_SLL, src1: 32'd0, src2: a << i, shamt: 5'd1});
    end
  endtask

  task automatic run_mul(input string name, input logic [31:0] a,
                         input logic [31:0] b, input bit glitch);
    alu_step_t   q[$];
    logic [31:0] exp_p;
    int          alu_n, seq_err, busy_err, done_k;
    alu_step_t   got;
    exp_p = a * b;
    build_model(a, b, q);
    alu_n = 0; seq_err = 0; busy_err = 0; done_k = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = a; bus.mplier = b;
    for (int k = 1; k <= 80 && done_k == 0; k++) begin
      @(negedge clk);
      bus.start = (glitch && k == 5);
      bus.mcand = $urandom; bus.mplier = $urandom;
      if (k == 1) check({name, ".product_cleared"}, bus.product, 0);
      if (bus.busy !== 1'b1) busy_err++;
      if (bus.alu_req === 1'b1) begin
        got = '{op: bus.alu_operation, src1: bus.alu_src1, src2: bus.alu_src2, shamt: bus.alu_shamt};
        if (alu_n >= q.size() || got !== q[alu_n]) seq_err++;
        alu_n++;
      end
      if (bus.done === 1'b1) begin
        done_k = k;
        check({name, ".product"}, bus.product, exp_p);
      end
    end
    bus.start = 1'b0;
    check({name, ".done_cycle"}, done_k, q.size() + 1);
    check({name, ".alu_cycles"}, alu_n, q.size());
    check({name, ".alu_seq_err"}, seq_err, 0);
    check({name, ".busy_err"}, busy_err, 0);
    @(negedge clk);
    check({name, ".idle_busy_done"}, {bus.busy, bus.done}, 2'b00);
    check({name, ".product_held"}, bus.product, exp_p);
  endtask

  initial begin
    bus.start = 1'b0; bus.mcand = '0; bus.mplier = '0;
    #2;
    check("reset.busy_done_req", {bus.busy, bus.done, bus.alu_req}, 3'b000);
    check("reset.product", bus.product, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle.alu_bus", {bus.alu_req, bus.alu_operation, bus.alu_src1, bus.alu_src2, bus.alu_shamt}, 0);

    run_mul("m3x5", 32'd3, 32'd5, 1'b0);
    run_mul("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_mul("zero_mp", 32'h1234_5678, 32'd0, 1'b0);
    run_mul("m7x4", 32'd7, 32'd4, 1'b0);
    run_mul("glitch", 32'hDEAD_BEEF, 32'h8000_0013, 1'b1);
    run_mul("top_bit", 32'h0000_0003, 32'h8000_0000, 1'b0);
    for (int r = 0; r < 6; r++) run_mul($sformatf("rand%0d", r), $urandom, $urandom, 1'b0);

    // Abort mid-operation with an asynchronous reset
    @(negedge clk);
    bus.start = 1'b1; bus.mcand = 32'd9; bus.mplier = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.pre_busy", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort.busy_done", {bus.busy, bus.done}, 2'b00);
    check("abort.product", bus.product, 0);
    check("abort.alu_bus", {bus.alu_req, bus.alu_operation, bus.alu_src1, bus.alu_src2, bus.alu_shamt}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_mul("after_abort", 32'h0001_0001, 32'h0000_00FF, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
# alu_mul_sequencer

Multi-cycle unsigned multiplier controller that computes the low 32 bits of a 32x32 product using the existing shared ALU. It uses only the ALU's add and shift-left operations. It sits beside the main datapath, and takes over the ALU's src1/src2/operation/shamt inputs while `alu_req` is high. It returns a registered product with a start/busy/done handshake. It has no arithmetic of its own except an internal bit counter and a multiplier shift register.

## Interface
Parameters:
- `WIDTH`, 32: operand and product width. Only 32 is supported.
- `OP_ADD`, 6'd27: ALU add opcode.
- `OP_SLL`, 6'd32: ALU shift-left opcode. The ALU shifts src2 by shamt.

Ports:
- `clk`  in  1  clock. Everything is rising-edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  request a multiply. Sampled only when `busy`=0.
- `mcand`  in  32  multiplicand. Captured on the accepted `start`.
- `mplier`  in  32  multiplier. Captured on the accepted `start`.
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse when `product` becomes valid.
- `product`  out  32  registered result. Held until the next accepted `start`.
- `alu_req`  out  1  high while the sequencer drives the ALU (ADD and SHIFT states). The datapath mux selects the sequencer on this.
- `alu_src1`  out  32  ALU src1.
- `alu_src2`  out  32  ALU src2.
- `alu_operation`  out  6  ALU opcode.
- `alu_shamt`  out  5  ALU shift amount.
- `alu_result`  in  32  combinational ALU result for the current cycle.

## Operation
- States: IDLE, ADD, SHIFT, DONE.
- Internal registers:
  - `acc` (32b)
  - `mc` (32b)
  - `mp` (32b)
  - `cnt` (5b)
- IDLE:
  - `start`=1 loads `acc`=0, `mc`=`mcand`, `mp`=`mplier`, `cnt`=0, and clears `product`.
  - Next state is ADD if `mplier[0]`, otherwise SHIFT.
- ADD:
  - Drives src1=`acc`, src2=`mc`, op=`OP_ADD`, shamt=0.
  - At the edge: `acc`<=`alu_result`, then go to SHIFT.
- SHIFT:
  - Drives src1=0, src2=`mc`, op=`OP_SLL`, shamt=1.
  - At the edge: `mc`<=`alu_result`, `mp`<=`mp`>>1, `cnt`<=`cnt`+1.
  - If `cnt`==31, go to DONE.
  - Otherwise go to ADD if `mp[1]`, else SHIFT.
- DONE:
  - `product`<=`acc`, `done`=1 for this cycle only, then go to IDLE.
- Arithmetic is modulo 2^32. Carries out of bit 31 are discarded, and bits shifted out of `mc` are lost.
- When `alu_req`=0, all `alu_*` outputs are driven to 0 (op 0 makes the ALU's default result 0).
- `start` while `busy`=1 is ignored, with no queuing.
- `start` in the DONE cycle is ignored. The earliest accepted restart is the following IDLE cycle.

## Timing
- Reset (async, asserted): state=IDLE, `busy`=0, `done`=0, `product`=0, `alu_req`=0, all `alu_*` outputs=0, and all internal registers=0.
- Reset mid-operation aborts immediately. No `done` pulse is produced and `product` reads 0.
- Acceptance edge is E0. `busy` rises after E0.
- Busy ALU cycles = 32 + popcount(`mplier`). The DONE cycle follows them.
- `done` asserts in cycle 33+popcount after E0, with `product` valid in the same cycle.
- Best case (`mplier`=0) is 32 SHIFT cycles. Worst case (`mplier`=0xFFFFFFFF) is 64 ALU cycles.
- `alu_result` is used combinationally within the same cycle. No ALU pipeline stage is assumed.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - In SHIFT, if (`mp`>>1)==0, go to DONE regardless of `cnt`.
  - In IDLE, `start` with `mplier`==0 goes directly to DONE, giving `product`=0 and `done` in the cycle after E0 with no ALU cycles.
  - Latency becomes (index of the highest set bit + 1) + popcount.
- `MUL_EARLY_EXIT_EN` undefined:
  - Fixed 32 SHIFT cycles, as described in Operation. `alu_req` and ALU traffic are fully data-independent apart from the ADD count.

## Test plan
- `mcand`=3, `mplier`=5, no macro -> `product`=15. `done` in cycle 35 after E0. `alu_req` high for 34 cycles, with OP_ADD at bit 0 and bit 2.
- `mcand`=0xFFFFFFFF, `mplier`=0xFFFFFFFF -> `product`=0x00000001. 64 ALU cycles alternating 27/32, then `done`.
- `mplier`=0, `mcand`=0x12345678 -> `product`=0. Without the macro, `done` at cycle 33. With the macro, `done` at cycle 1.
- With the macro, `mcand`=7, `mplier`=4 -> sequence SHIFT, SHIFT, ADD, SHIFT, DONE, with `product`=28 and `done` at cycle 5.
- `start` pulsed with new operands mid-operation -> ignored, and the first product completes unchanged. `rst` asserted at cycle 10 -> `busy`, `done`, `product` and `alu_*` all 0 immediately, and a new `start` after release is accepted.
- `alu_req`=0 in IDLE -> `alu_operation`=0, `alu_src1`=0, `alu_src2`=0, `alu_shamt`=0.
